// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (multiplier and divider).
// Holds the controller state encoding and the default Q-format constants.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_FRAC  = 5;

endpackage

// File: rtl/shift_registerPQ.sv
// Combined {P,Q} register of the shift-add multiplier: parallel load, clear, and a
// right shift that takes the adder sum into P with the adder carry as serial input.
module shift_registerPQ
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               shift,
    input  logic [2*WIDTH:0]   load_value,
    input  logic               serial_in,
    input  logic [WIDTH-1:0]   sum_in,
    output logic [2*WIDTH:0]   data
);

    // A shift replaces P with (carry,sum) and moves the whole pair right by one,
    // so the sum LSB drops into the top of Q and Q's LSB falls out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (load) begin
            data <= load_value;
        end else if (shift) begin
            data <= {1'b0, serial_in, sum_in, data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/unsigned_fixed_point_multiplier.sv
// Sequential shift-add multiplier for unsigned Q(WIDTH-FRAC).FRAC operands.
// Define MULT_ROUND_EN to round half-up instead of truncating the product.
module unsigned_fixed_point_multiplier
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FRAC  = DEFAULT_FRAC
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] m;
    logic [2*WIDTH:0] pq;
    logic [WIDTH:0]   addsum;
    logic [WIDTH:0]   field;
    logic             ovf_next;
    logic [WIDTH-1:0] res_next;
    logic             load_pq;
    logic             shift_pq;
    logic             clear_pq;
    logic             unused_low_bits;

    assign addsum   = {1'b0, pq[2*WIDTH-1:WIDTH]} + {1'b0, (pq[0] ? m : '0)};
    assign load_pq  = (state == IDLE) && start;
    assign shift_pq = (state == CALC) && (count != LAST);
    assign clear_pq = (state == DONE);
    assign unused_low_bits = ^pq[FRAC-1:0];

    shift_registerPQ #(
        .WIDTH(WIDTH)
    ) u_pq (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_pq),
        .load      (load_pq),
        .shift     (shift_pq),
        .load_value({{(WIDTH+1){1'b0}}, b}),
        .serial_in (addsum[WIDTH]),
        .sum_in    (addsum[WIDTH-1:0]),
        .data      (pq)
    );

    // Result extraction from the finished product held in {P[WIDTH-1:0],Q}
    always_comb begin
        field = {1'b0, pq[FRAC+WIDTH-1:FRAC]};
`ifdef MULT_ROUND_EN
        field = field + {{WIDTH{1'b0}}, pq[FRAC-1]};
`endif
        ovf_next = (|pq[2*WIDTH:FRAC+WIDTH]) | field[WIDTH];
        res_next = ovf_next ? '1 : field[WIDTH-1:0];
    end

    // CALC spends WIDTH cycles shifting plus one cycle with the product settled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            m        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        m     <= a;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= CALC;
                    count <= '0;
                end
                CALC: begin
                    if (count == LAST) begin
                        state    <= DONE;
                        result   <= res_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_fixed_point_multiplier.sv
// Scoreboard bench for unsigned_fixed_point_multiplier (WIDTH=10, FRAC=5); honours MULT_ROUND_EN.
module tb_unsigned_fixed_point_multiplier;

    localparam int WIDTH   = 10;
    localparam int FRAC    = 5;
    localparam int LATENCY = WIDTH + 2;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    unsigned_fixed_point_multiplier #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact product scaled back by 2^FRAC, optionally rounded, then saturated
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int when);
        exp_t e;
        longint unsigned prod;
        longint unsigned q;
        prod = longint'(x) * longint'(y);
        q = prod >> FRAC;
`ifdef MULT_ROUND_EN
        q = q + ((prod >> (FRAC - 1)) & 64'd1);
`endif
        if (q > 64'd1023) begin
            e.res = '1;
            e.ovf = 1'b1;
        end else begin
            e.res = q[WIDTH-1:0];
            e.ovf = 1'b0;
        end
        e.cyc = when;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: busy still %0d expected 0", busy);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: pending %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        waitIdle();
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(x, y, cyc + LATENCY));
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic ignoredPulse(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst) begin
            if (prev_done) begin
                checkOutput("busy_after_done", 32'(busy), 32'd0);
                checkOutput("done_one_cycle", 32'(done), 32'd0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("result", 32'(result), 32'(mon_e.res));
                    checkOutput("overflow", 32'(overflow), 32'(mon_e.ovf));
                    checkOutput("latency", 32'(cyc), 32'(mon_e.cyc));
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    initial begin
        int k;
        int j;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        #1 rst = 1'b0;
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        applyStimulus(10'd48, 10'd64);
        drain();
        applyStimulus(10'd1023, 10'd1023);
        applyStimulus(10'd1, 10'd17);
        applyStimulus(10'd0, 10'd1023);
        drain();

        // Start re-pulsed with new operands mid-calculation must be ignored
        applyStimulus(10'd48, 10'd64);
        repeat (4) @(negedge clk);
        ignoredPulse(10'd1023, 10'd1023);
        drain();

        // Start held high through DONE is accepted only after returning to IDLE
        waitIdle();
        a = 10'd40;
        b = 10'd70;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back(model(10'd40, 10'd70, k + LATENCY));
        sb.push_back(model(10'd100, 10'd9, k + 2 + 2 * LATENCY));
        @(negedge clk);
        a = 10'd100;
        b = 10'd9;
        j = 0;
        while (cyc < k + LATENCY + 2 && j < 100) begin
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of CALC abandons the operation
        applyStimulus(10'd100, 10'd200);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_result", 32'(result), 32'd0);
        checkOutput("midreset_overflow", 32'(overflow), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_idle", 32'(busy), 32'd0);
        applyStimulus(10'd32, 10'd32);
        drain();

        for (int i = 0; i < 30; i++) begin
            ra = WIDTH'($urandom_range(0, 1023));
            rb = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 63)) : WIDTH'($urandom_range(0, 1023));
            applyStimulus(ra, rb);
            if ($urandom_range(0, 2) == 0) begin
                j = $urandom_range(1, 10);
                repeat (j - 1) @(negedge clk);
                ignoredPulse(WIDTH'($urandom), WIDTH'($urandom));
            end
            drain();
        end

        waitIdle();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
